// File: rtl/decode_issue_stage.sv
// decode_issue_stage: MIPS decode/issue with writeback bypass,
// load-use bubble insertion and a registered ID/EX handshake.
module decode_issue_stage #(
    parameter int ADDRESS_WIDTH   = 5,
    parameter int REG_SIZE        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       instr_valid,
    input  logic [31:0]                instr,
    input  logic [REG_SIZE-1:0]        instr_pc,
    output logic                       instr_ready,
    input  logic                       flush,
    output logic [ADDRESS_WIDTH-1:0]   rf_read_a_addr,
    output logic [ADDRESS_WIDTH-1:0]   rf_read_b_addr,
    input  logic [REG_SIZE-1:0]        rf_a_data,
    input  logic [REG_SIZE-1:0]        rf_b_data,
    input  logic                       wb_write_en,
    input  logic [ADDRESS_WIDTH-1:0]   wb_write_addr,
    input  logic [REG_SIZE-1:0]        wb_write_data,
    input  logic                       ex_ready,
    output logic                       ex_valid,
    output logic [REG_SIZE-1:0]        ex_pc,
    output logic [5:0]                 ex_opcode,
    output logic [5:0]                 ex_funct,
    output logic [REG_SIZE-1:0]        ex_rs_data,
    output logic [REG_SIZE-1:0]        ex_rt_data,
    output logic [REG_SIZE-1:0]        ex_imm_sext,
    output logic [ADDRESS_WIDTH-1:0]   ex_dest_addr,
    output logic                       ex_reg_write,
    output logic                       ex_mem_read,
    output logic                       ex_mem_write,
    output logic                       hazard_stall,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t                       r_state;
    logic                         r_ex_valid;
    logic [REG_SIZE-1:0]          r_ex_pc;
    logic [5:0]                   r_ex_opcode;
    logic [5:0]                   r_ex_funct;
    logic [REG_SIZE-1:0]          r_ex_rs_data;
    logic [REG_SIZE-1:0]          r_ex_rt_data;
    logic [REG_SIZE-1:0]          r_ex_imm;
    logic [ADDRESS_WIDTH-1:0]     r_ex_dest;
    logic                         r_ex_reg_write;
    logic                         r_ex_mem_read;
    logic                         r_ex_mem_write;
    logic                         r_hazard_stall;
    logic [STALL_CNT_WIDTH-1:0]   r_stall_count;

    logic [5:0]                   w_opcode;
    logic [5:0]                   w_funct;
    logic [ADDRESS_WIDTH-1:0]     w_rs;
    logic [ADDRESS_WIDTH-1:0]     w_rt;
    logic [ADDRESS_WIDTH-1:0]     w_rd;
    logic [REG_SIZE-1:0]          w_imm;
    logic [ADDRESS_WIDTH-1:0]     w_dest;
    logic                         w_reg_write;
    logic                         w_mem_read;
    logic                         w_mem_write;
    logic                         w_rt_src;
    logic [REG_SIZE-1:0]          w_rs_data;
    logic [REG_SIZE-1:0]          w_rt_data;
    logic                         w_advance;
    logic                         w_hazard;
    logic                         w_load;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_rs     = ADDRESS_WIDTH'(instr[25:21]);
    assign w_rt     = ADDRESS_WIDTH'(instr[20:16]);
    assign w_rd     = ADDRESS_WIDTH'(instr[15:11]);
    assign w_imm    = {{(REG_SIZE-16){instr[15]}}, instr[15:0]};

    assign rf_read_a_addr = w_rs;
    assign rf_read_b_addr = w_rt;

    // Control decode; a zero destination never writes.
    always_comb begin
        w_dest      = '0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_rt_src    = 1'b0;
        unique case (1'b1)
            w_opcode == OP_RTYPE: begin
                w_dest      = w_rd;
                w_reg_write = (w_funct != FN_JR);
                w_rt_src    = 1'b1;
            end
            w_opcode[5:3] == 3'b001: begin
                w_dest      = w_rt;
                w_reg_write = 1'b1;
            end
            w_opcode == OP_LW: begin
                w_dest      = w_rt;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            w_opcode == OP_SW: begin
                w_mem_write = 1'b1;
                w_rt_src    = 1'b1;
            end
            w_opcode == OP_BEQ,
            w_opcode == OP_BNE: begin
                w_rt_src    = 1'b1;
            end
            w_opcode == OP_JAL: begin
                w_dest      = ADDRESS_WIDTH'(31);
                w_reg_write = 1'b1;
            end
            default: begin
            end
        endcase
        if (w_dest == '0) begin
            w_reg_write = 1'b0;
        end
    end

    // Operand select: $zero, then same-cycle writeback, then RF.
    always_comb begin
        w_rs_data = rf_a_data;
        w_rt_data = rf_b_data;
        if (w_rs == '0) begin
            w_rs_data = '0;
        end else if (wb_write_en && wb_write_addr == w_rs) begin
            w_rs_data = wb_write_data;
        end
        if (w_rt == '0) begin
            w_rt_data = '0;
        end else if (wb_write_en && wb_write_addr == w_rt) begin
            w_rt_data = wb_write_data;
        end
    end

    assign w_advance = ex_ready | ~r_ex_valid;
    assign w_hazard  = instr_valid & r_ex_valid & r_ex_mem_read
                     & r_ex_reg_write
                     & ((r_ex_dest == w_rs)
                       | (w_rt_src & (r_ex_dest == w_rt)));
    assign w_load    = ~flush & w_advance & ~w_hazard;

    assign instr_ready = ~reset & ((w_advance & ~w_hazard) | flush);

    // Issue FSM: flush, load-use bubble, stall counter, ex_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_ex_valid     <= 1'b0;
            r_hazard_stall <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_hazard_stall <= 1'b0;
            if (flush) begin
                r_ex_valid <= 1'b0;
                r_state    <= RUN;
            end else begin
                unique case (r_state)
                    RUN: begin
                        if (w_advance && w_hazard) begin
                            r_ex_valid     <= 1'b0;
                            r_hazard_stall <= 1'b1;
                            r_state        <= STALL;
                            if (r_stall_count != '1) begin
                                r_stall_count <= r_stall_count + 1'b1;
                            end
                        end else if (w_load) begin
                            r_ex_valid <= instr_valid;
                        end
                    end
                    STALL: begin
                        if (w_load) begin
                            r_ex_valid <= instr_valid;
                            r_state    <= RUN;
                        end
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    // Capture the decoded bundle whenever a new instruction loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_pc        <= '0;
            r_ex_opcode    <= '0;
            r_ex_funct     <= '0;
            r_ex_rs_data   <= '0;
            r_ex_rt_data   <= '0;
            r_ex_imm       <= '0;
            r_ex_dest      <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
        end else if (w_load) begin
            r_ex_pc        <= instr_pc;
            r_ex_opcode    <= w_opcode;
            r_ex_funct     <= w_funct;
            r_ex_rs_data   <= w_rs_data;
            r_ex_rt_data   <= w_rt_data;
            r_ex_imm       <= w_imm;
            r_ex_dest      <= w_dest;
            r_ex_reg_write <= w_reg_write;
            r_ex_mem_read  <= w_mem_read;
            r_ex_mem_write <= w_mem_write;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_pc        = r_ex_pc;
    assign ex_opcode    = r_ex_opcode;
    assign ex_funct     = r_ex_funct;
    assign ex_rs_data   = r_ex_rs_data;
    assign ex_rt_data   = r_ex_rt_data;
    assign ex_imm_sext  = r_ex_imm;
    assign ex_dest_addr = r_ex_dest;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;
    assign hazard_stall = r_hazard_stall;
    assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed instructions,
// expected ID/EX bundles queued at issue and popped on handshake.
module tb_decode_issue_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
    } bund_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        flush;
    logic [4:0]  rf_read_a_addr;
    logic [4:0]  rf_read_b_addr;
    logic [31:0] rf_a_data;
    logic [31:0] rf_b_data;
    logic        wb_write_en;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm_sext;
    logic [4:0]  ex_dest_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        hazard_stall;
    logic [15:0] stall_count;

    int    total = 0;
    int    bad   = 0;
    bund_t q[$];
    bund_t act;
    bund_t ex_x;
    bund_t popped;

    decode_issue_stage dut (
        .clock          (clock),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .flush          (flush),
        .rf_read_a_addr (rf_read_a_addr),
        .rf_read_b_addr (rf_read_b_addr),
        .rf_a_data      (rf_a_data),
        .rf_b_data      (rf_b_data),
        .wb_write_en    (wb_write_en),
        .wb_write_addr  (wb_write_addr),
        .wb_write_data  (wb_write_data),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_opcode      (ex_opcode),
        .ex_funct       (ex_funct),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm_sext    (ex_imm_sext),
        .ex_dest_addr   (ex_dest_addr),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .hazard_stall   (hazard_stall),
        .stall_count    (stall_count)
    );

    always #5 clock = ~clock;

    assign act = {ex_pc, ex_opcode, ex_funct, ex_rs_data, ex_rt_data,
                  ex_imm_sext, ex_dest_addr, ex_reg_write,
                  ex_mem_read, ex_mem_write};

    function automatic bund_t mk(
        input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn,
        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
        input logic [4:0] d, input logic rw, input logic mr, input logic mw);
        bund_t b;
        b = '{pc, op, fn, rs, rt, imm, d, rw, mr, mw};
        return b;
    endfunction

    task automatic chk(input string nm, input logic [147:0] a,
                       input logic [147:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, a, e, $time);
        end
    endtask

    // Present an instruction until accepted; queue its bundle.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input bund_t e);
        bit ok;
        ok = 1'b0;
        instr_valid = 1'b1;
        instr       = ins;
        instr_pc    = pc;
        rf_a_data   = a;
        rf_b_data   = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (instr_ready) begin
                q.push_back(e);
                ok = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        chk("issue_accepted", {147'd0, ok}, 148'd1);
    endtask

    // Monitor: pop and compare on every ID/EX handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && ex_valid && ex_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_bundle", act, 148'd0);
                end else begin
                    popped = q.pop_front();
                    chk("bundle", act, popped);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        instr_valid   = 1'b0;
        instr         = '0;
        instr_pc      = '0;
        flush         = 1'b0;
        rf_a_data     = '0;
        rf_b_data     = '0;
        wb_write_en   = 1'b0;
        wb_write_addr = '0;
        wb_write_data = '0;
        ex_ready      = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_bundle", act, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_hazard_stall", hazard_stall, 0);
        chk("rst_instr_ready", instr_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // ADDI $3,$0,5
        issue(32'h20030005, 32'h100, 32'h11, 32'h22,
              mk(32'h100, 6'h08, 6'h05, 0, 32'h22, 32'h5, 5'd3, 1, 0, 0));

        // LW $4,0($1) then ADD $5,$4,$2: one bubble
        issue(32'h8C240000, 32'h104, 32'h1000, 32'h44,
              mk(32'h104, 6'h23, 6'h00, 32'h1000, 32'h44, 0, 5'd4, 1, 1, 0));
        instr_valid = 1'b1;
        instr       = 32'h00822820;
        instr_pc    = 32'h108;
        @(negedge clock);
        chk("ldu_instr_ready", instr_ready, 0);
        chk("ldu_pre_hazard", hazard_stall, 0);
        @(posedge clock);
        #1;
        chk("ldu_hazard_stall", hazard_stall, 1);
        chk("ldu_stall_count", stall_count, 1);
        chk("ldu_bubble", ex_valid, 0);
        chk("ldu_ready_after", instr_ready, 1);
        issue(32'h00822820, 32'h108, 32'h55, 32'h66,
              mk(32'h108, 6'h00, 6'h20, 32'h55, 32'h66, 32'h2820,
                 5'd5, 1, 0, 0));
        chk("ldu_stall_clear", hazard_stall, 0);

        // SW $7,4($0) with writeback of $7 in flight
        wb_write_en   = 1'b1;
        wb_write_addr = 5'd7;
        wb_write_data = 32'hDEADBEEF;
        instr         = 32'hAC070004;
        #1;
        chk("sw_rf_b_addr", rf_read_b_addr, 7);
        chk("sw_rf_a_addr", rf_read_a_addr, 0);
        issue(32'hAC070004, 32'h10C, 32'h77, 32'h0,
              mk(32'h10C, 6'h2B, 6'h04, 0, 32'hDEADBEEF, 32'h4,
                 5'd0, 0, 0, 1));

        // ORI $9,$0,0x1234 with a write to $0 in flight
        wb_write_addr = 5'd0;
        wb_write_data = 32'hFFFFFFFF;
        issue(32'h34091234, 32'h110, 32'hAAAA, 32'h99,
              mk(32'h110, 6'h0D, 6'h34, 0, 32'h99, 32'h1234,
                 5'd9, 1, 0, 0));

        // ADDI $6,$3,-1 with $3 bypassed from writeback
        wb_write_addr = 5'd3;
        wb_write_data = 32'h12345678;
        issue(32'h2066FFFF, 32'h114, 32'h33, 32'h66,
              mk(32'h114, 6'h08, 6'h3F, 32'h12345678, 32'h66,
                 32'hFFFFFFFF, 5'd6, 1, 0, 0));
        wb_write_en = 1'b0;

        // JR $31 (rd field 31): no register write
        issue(32'h03E0F808, 32'h118, 32'h400, 32'h5,
              mk(32'h118, 6'h00, 6'h08, 32'h400, 0, 32'hFFFFF808,
                 5'd31, 0, 0, 0));
        // ADD $0,$1,$2: destination zero suppresses write
        issue(32'h00220020, 32'h11C, 32'h10, 32'h20,
              mk(32'h11C, 6'h00, 6'h20, 32'h10, 32'h20, 32'h20,
                 5'd0, 0, 0, 0));
        // JAL
        issue(32'h0C000010, 32'h120, 32'h1, 32'h2,
              mk(32'h120, 6'h03, 6'h10, 0, 0, 32'h10, 5'd31, 1, 0, 0));
        // BEQ $1,$2
        issue(32'h10220003, 32'h124, 32'h1, 32'h2,
              mk(32'h124, 6'h04, 6'h03, 32'h1, 32'h2, 32'h3,
                 5'd0, 0, 0, 0));
        // unknown opcode 0x3F issues as a NOP
        issue(32'hFC000000, 32'h128, 32'h0, 32'h0,
              mk(32'h128, 6'h3F, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0));

        // EX back-pressure for 3 cycles
        ex_x = mk(32'h12C, 6'h0D, 6'h3F, 32'h7, 32'h9, 32'hFF,
                  5'd2, 1, 0, 0);
        issue(32'h342200FF, 32'h12C, 32'h7, 32'h9, ex_x);
        ex_ready    = 1'b0;
        instr_valid = 1'b1;
        instr       = 32'h20030005;
        instr_pc    = 32'h130;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hold_instr_ready", instr_ready, 0);
            chk("hold_ex_valid", ex_valid, 1);
            chk("hold_bundle", act, ex_x);
        end
        @(posedge clock);
        #1 ex_ready = 1'b1;
        issue(32'h20030005, 32'h130, 32'h11, 32'h22,
              mk(32'h130, 6'h08, 6'h05, 0, 32'h22, 32'h5, 5'd3, 1, 0, 0));

        // LW $8 then ADDI $8,$2,1: rt is not a source, no stall
        issue(32'h8C280000, 32'h134, 32'h1000, 32'h88,
              mk(32'h134, 6'h23, 6'h00, 32'h1000, 32'h88, 0,
                 5'd8, 1, 1, 0));
        instr_valid = 1'b1;
        instr       = 32'h20480001;
        #1;
        chk("rt_nosrc_ready", instr_ready, 1);
        issue(32'h20480001, 32'h138, 32'h2, 32'h3,
              mk(32'h138, 6'h08, 6'h01, 32'h2, 32'h3, 32'h1,
                 5'd8, 1, 0, 0));
        chk("rt_nosrc_count", stall_count, 1);

        // flush during STALL
        issue(32'h8C240000, 32'h13C, 32'h1000, 32'h44,
              mk(32'h13C, 6'h23, 6'h00, 32'h1000, 32'h44, 0,
                 5'd4, 1, 1, 0));
        instr_valid = 1'b1;
        instr       = 32'h00822820;
        instr_pc    = 32'h140;
        @(negedge clock);
        chk("fl_ldu_ready", instr_ready, 0);
        @(posedge clock);
        #1;
        chk("fl_hazard_stall", hazard_stall, 1);
        chk("fl_stall_count", stall_count, 2);
        flush = 1'b1;
        #1;
        chk("fl_instr_ready", instr_ready, 1);
        @(posedge clock);
        #1;
        flush       = 1'b0;
        instr_valid = 1'b0;
        chk("fl_ex_valid", ex_valid, 0);
        chk("fl_count_kept", stall_count, 2);
        chk("fl_hazard_clear", hazard_stall, 0);
        issue(32'h20030005, 32'h144, 32'h11, 32'h22,
              mk(32'h144, 6'h08, 6'h05, 0, 32'h22, 32'h5, 5'd3, 1, 0, 0));

        // reset in the middle of a stall
        issue(32'h8C240000, 32'h148, 32'h1000, 32'h44,
              mk(32'h148, 6'h23, 6'h00, 32'h1000, 32'h44, 0,
                 5'd4, 1, 1, 0));
        instr_valid = 1'b1;
        instr       = 32'h00822820;
        instr_pc    = 32'h14C;
        @(posedge clock);
        #1;
        chk("rs_hazard_stall", hazard_stall, 1);
        chk("rs_stall_count", stall_count, 3);
        #2 reset = 1'b1;
        #1;
        chk("rs_ex_valid", ex_valid, 0);
        chk("rs_stall_count0", stall_count, 0);
        chk("rs_hazard0", hazard_stall, 0);
        chk("rs_instr_ready", instr_ready, 0);
        chk("rs_bundle", act, 0);
        instr_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        repeat (3) @(posedge clock);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
